// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: interlocks, MDU busy window and M-stage flushes.
// Latency: enables/clears are combinational for the next edge; MDU busy starts the cycle after the start.
// Backpressure: a stall freezes PC and F/D and injects a D/E bubble. Optional PIPE_CTRL_PERF_EN adds a stall counter.
module pipe_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  e_wa,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        d_is_mdu,
    input  logic        e_mdu_start,
    input  logic        e_mdu_div,
    input  logic        m_exc,
    input  logic        m_eret,
    output logic        pc_en,
    output logic        f2d_en,
    output logic        d2e_en,
    output logic        e2m_en,
    output logic        m2w_en,
    output logic        f2d_clr,
    output logic        d2e_clr,
    output logic        e2m_clr,
    output logic        m2w_clr,
    output logic        stall,
    output logic        mdu_busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYC);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

    logic [3:0] mdu_cnt_q, mdu_cnt_d;
    logic       rs_haz, rt_haz, mdu_haz, flush;

    // A source hazards when a producer still needs more cycles than the consumer can wait; $0 never hazards.
    function automatic logic src_haz(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] ewa, input logic [1:0] etn,
                                     input logic [4:0] mwa, input logic [1:0] mtn);
        src_haz = (r != 5'd0) && (tuse != 2'd3) &&
                  (((ewa == r) && (etn > tuse)) || ((mwa == r) && (mtn > tuse)));
    endfunction

    assign rs_haz   = src_haz(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
    assign rt_haz   = src_haz(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    assign mdu_busy = (mdu_cnt_q != 4'd0);
    assign mdu_haz  = d_is_mdu & (mdu_busy | e_mdu_start);
    assign flush    = m_exc | m_eret;
    assign stall    = (rs_haz | rt_haz | mdu_haz) & ~flush;

    always_comb begin
        pc_en   = 1'b1;
        f2d_en  = 1'b1;
        d2e_en  = 1'b1;
        e2m_en  = 1'b1;
        m2w_en  = 1'b1;
        f2d_clr = 1'b0;
        d2e_clr = 1'b0;
        e2m_clr = 1'b0;
        m2w_clr = 1'b0;
        if (m_exc) begin
            f2d_clr = 1'b1;
            d2e_clr = 1'b1;
            e2m_clr = 1'b1;
            m2w_clr = 1'b1;
        end else if (m_eret) begin
            // eret itself sits in M and must still reach W
            f2d_clr = 1'b1;
            d2e_clr = 1'b1;
            e2m_clr = 1'b1;
        end else if (stall) begin
            pc_en   = 1'b0;
            f2d_en  = 1'b0;
            d2e_clr = 1'b1;
        end
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (e_mdu_start && !mdu_busy && !flush)
            mdu_cnt_d = e_mdu_div ? DIV_N : MULT_N;
        else if (mdu_busy)
            mdu_cnt_d = mdu_cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) mdu_cnt_q <= 4'd0;
        else       mdu_cnt_q <= mdu_cnt_d;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk) begin
        if (reset)      perf_q <= 32'd0;
        else if (stall) perf_q <= perf_q + 32'd1;
    end
    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, multi-cycle MDU/flush/reset sequences, random vs. reference model.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_wa, m_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_mdu, e_mdu_start, e_mdu_div, m_exc, m_eret;
    logic       pc_en, f2d_en, d2e_en, e2m_en, m2w_en;
    logic       f2d_clr, d2e_clr, e2m_clr, m2w_clr, stall, mdu_busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .e_wa(e_wa), .m_wa(m_wa), .e_tnew(e_tnew), .m_tnew(m_tnew),
        .d_is_mdu(d_is_mdu), .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
        .m_exc(m_exc), .m_eret(m_eret),
        .pc_en(pc_en), .f2d_en(f2d_en), .d2e_en(d2e_en), .e2m_en(e2m_en), .m2w_en(m2w_en),
        .f2d_clr(f2d_clr), .d2e_clr(d2e_clr), .e2m_clr(e2m_clr), .m2w_clr(m2w_clr),
        .stall(stall), .mdu_busy(mdu_busy)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // {pc_en,f2d_en,d2e_en,e2m_en,m2w_en, f2d_clr,d2e_clr,e2m_clr,m2w_clr, stall}
    localparam logic [9:0] P_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] P_STALL = 10'b00111_0100_1;
    localparam logic [9:0] P_EXC   = 10'b11111_1111_0;
    localparam logic [9:0] P_ERET  = 10'b11111_1110_0;

    wire [9:0] outs = {pc_en, f2d_en, d2e_en, e2m_en, m2w_en,
                       f2d_clr, d2e_clr, e2m_clr, m2w_clr, stall};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        e_wa = 5'd0; m_wa = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
        d_is_mdu = 1'b0; e_mdu_start = 1'b0; e_mdu_div = 1'b0;
        m_exc = 1'b0; m_eret = 1'b0;
    endtask

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] tu_rs, tu_rt;
        logic [4:0] ewa, mwa;
        logic [1:0] etn, mtn;
        logic       mdu, exc, eret;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[10];

    // Reference: hazard rule straight from the register/timing definition; MDU window as a cycle deadline.
    function automatic logic [9:0] ref_out(input logic [4:0] rs, rt, input logic [1:0] trs, trt,
                                           input logic [4:0] ewa, mwa, input logic [1:0] etn, mtn,
                                           input logic mdu, busy, start, exc, eret);
        logic haz;
        haz = 1'b0;
        if (rs != 0 && trs != 3 && ((ewa == rs && etn > trs) || (mwa == rs && mtn > trs))) haz = 1'b1;
        if (rt != 0 && trt != 3 && ((ewa == rt && etn > trt) || (mwa == rt && mtn > trt))) haz = 1'b1;
        if (mdu && (busy || start)) haz = 1'b1;
        if (exc)       return P_EXC;
        else if (eret) return P_ERET;
        else if (haz)  return P_STALL;
        return P_RUN;
    endfunction

    initial begin
        int cyc;
        int busy_end;
        logic mbusy;
        logic [9:0] e;

        tbl[0] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, P_STALL, "load_use_e"};
        tbl[1] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 5'd5, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, P_RUN,   "load_use_m_ready"};
        tbl[2] = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, P_RUN,   "zero_reg"};
        tbl[3] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 5'd5, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, P_STALL, "m_haz"};
        tbl[4] = '{5'd0, 5'd7, 2'd3, 2'd0, 5'd7, 5'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, P_STALL, "rt_haz"};
        tbl[5] = '{5'd5, 5'd0, 2'd3, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, P_RUN,   "unused_src"};
        tbl[6] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, P_EXC,   "exc_over_stall"};
        tbl[7] = '{5'd5, 5'd0, 2'd1, 2'd3, 5'd5, 5'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, P_ERET,  "eret_over_stall"};
        tbl[8] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, P_EXC,   "exc_over_eret"};
        tbl[9] = '{5'd3, 5'd3, 2'd2, 2'd2, 5'd3, 5'd3, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, P_RUN,   "mdu_idle_equal_t"};

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("reset_outs", 32'(outs), 32'(P_RUN));
        chk("reset_busy", 32'(mdu_busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d_rs = tbl[i].rs; d_rt = tbl[i].rt; d_tuse_rs = tbl[i].tu_rs; d_tuse_rt = tbl[i].tu_rt;
            e_wa = tbl[i].ewa; m_wa = tbl[i].mwa; e_tnew = tbl[i].etn; m_tnew = tbl[i].mtn;
            d_is_mdu = tbl[i].mdu; m_exc = tbl[i].exc; m_eret = tbl[i].eret;
            #1;
            chk(tbl[i].name, 32'(outs), 32'(tbl[i].exp));
        end

        // div: start cycle plus 10 busy cycles stall an MDU consumer
        @(negedge clk);
        idle(); d_is_mdu = 1'b1; e_mdu_start = 1'b1; e_mdu_div = 1'b1;
        #1;
        chk("div_start_stall", 32'(outs), 32'(P_STALL));
        chk("div_start_busy", 32'(mdu_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e_mdu_start = (i == 3);   // restart while busy must not reload
            #1;
            chk("div_busy", 32'(mdu_busy), 32'd1);
            chk("div_stall", 32'(stall), 32'd1);
        end
        @(negedge clk);
        e_mdu_start = 1'b0;
        #1;
        chk("div_release_busy", 32'(mdu_busy), 32'd0);
        chk("div_release_outs", 32'(outs), 32'(P_RUN));

        // exception cancels a start in E
        @(negedge clk);
        idle(); d_is_mdu = 1'b1; e_mdu_start = 1'b1; m_exc = 1'b1;
        #1;
        chk("exc_start_outs", 32'(outs), 32'(P_EXC));
        @(negedge clk);
        idle();
        #1;
        chk("exc_start_busy", 32'(mdu_busy), 32'd0);

        // reset in the third cycle of a mult
        @(negedge clk);
        e_mdu_start = 1'b1;
        @(negedge clk);
        e_mdu_start = 1'b0;
        #1;
        chk("mult_busy_c1", 32'(mdu_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mult_reset_busy", 32'(mdu_busy), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_rs = 5'd5; d_tuse_rs = 2'd1; e_wa = 5'd5; e_tnew = 2'd2;
        end
        @(negedge clk);
        idle();
        #1;
        chk("perf_three", perf_stall_cnt, 32'd3);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        #1;
        chk("perf_reset", perf_stall_cnt, 32'd0);
`endif

        // random traffic against the reference model; small register range forces collisions
        cyc = 0;
        busy_end = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            e_wa = 5'($urandom_range(0, 3)); m_wa = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
            e_tnew = 2'($urandom_range(0, 3)); m_tnew = 2'($urandom_range(0, 3));
            d_is_mdu = ($urandom_range(0, 1) == 1);
            e_mdu_start = ($urandom_range(0, 3) == 0);
            e_mdu_div = ($urandom_range(0, 1) == 1);
            m_exc = ($urandom_range(0, 7) == 0);
            m_eret = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 63) == 0);
            #1;
            mbusy = (cyc < busy_end);
            if (!reset) begin
                e = ref_out(d_rs, d_rt, d_tuse_rs, d_tuse_rt, e_wa, m_wa, e_tnew, m_tnew,
                            d_is_mdu, mbusy, e_mdu_start, m_exc, m_eret);
                chk("rand_outs", 32'(outs), 32'(e));
                chk("rand_busy", 32'(mdu_busy), 32'(mbusy));
            end
            if (reset)
                busy_end = 0;
            else if (e_mdu_start && !mbusy && !m_exc && !m_eret)
                busy_end = cyc + 1 + (e_mdu_div ? 10 : 5);
            cyc++;
        end
        @(negedge clk);
        idle();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
